brightness_control_decode: RTL and testbench

Avalon-ST video decoder that sits directly upstream of `brightness_control_encode` in the brightness-control pipeline. It parses the incoming video stream, strips control packets (type 0xF) and latches their width/height/interlaced fields, discards packets of any other non-video type, and forwards only the payload of video data packets (type 0x0) with the type header beat removed. The first pixel of each forwarded packet carries `dout_startofpacket`, which is the stream format the encode stage consumes.

---
 rtl/brightness_control_decode_if.sv | 38 +++
 rtl/brightness_control_decode.sv | 229 ++++++++++++++++++++++
 tb/tb_brightness_control_decode.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/brightness_control_decode_if.sv
// ---------------------------------------------------------------------------
// brightness_control_decode_if
//   Avalon-ST bundle around brightness_control_decode: the input stream
//   (din_*) and the output stream (dout_*).
//   slave  : decoder view (sinks din, sources dout).
//   master : environment view (sources din, sinks dout).
// Parameters:
//   DATA_WIDTH : stream data width (DATA_BITS*DATA_PLANES of the decoder).
// ---------------------------------------------------------------------------
interface brightness_control_decode_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] din_data;
    logic                  din_valid;
    logic                  din_startofpacket;
    logic                  din_endofpacket;
    logic                  din_ready;

    logic [DATA_WIDTH-1:0] dout_data;
    logic                  dout_valid;
    logic                  dout_startofpacket;
    logic                  dout_endofpacket;
    logic                  dout_ready;

    modport slave (
        input  din_data, din_valid, din_startofpacket, din_endofpacket,
        output din_ready,
        output dout_data, dout_valid, dout_startofpacket, dout_endofpacket,
        input  dout_ready
    );

    modport master (
        output din_data, din_valid, din_startofpacket, din_endofpacket,
        input  din_ready,
        input  dout_data, dout_valid, dout_startofpacket, dout_endofpacket,
        output dout_ready
    );
endinterface

// File: rtl/brightness_control_decode.sv
// ---------------------------------------------------------------------------
// brightness_control_decode
//   Avalon-ST video decoder feeding brightness_control_encode. Control packets
//   (type 0xF) are stripped and their width/height/interlaced nibbles latched,
//   other non-video packets are discarded, and video packets (type 0x0) are
//   forwarded without their header beat; the first forwarded pixel carries
//   dout_startofpacket.
//
// Ports:
//   clk, rst          : single clock, synchronous active-high reset
//   bus (slave)       : din_* input stream / dout_* output stream
//   video_width       : last committed width  (16 bit)
//   video_height      : last committed height (16 bit)
//   video_interlaced  : last committed interlace nibble
//   ctrl_update       : one-cycle pulse when control fields are committed
//   ctrl_error        : one-cycle pulse after a short control packet
//
// Build option:
//   BRIGHTNESS_CONTROL_DECODE_CHECK_EN
//     defined   : control nibbles collect in a shadow copy and commit only at
//                 EOP once all 9 nibbles arrived; a short packet leaves the
//                 fields unchanged and pulses ctrl_error.
//     undefined : each nibble writes the live fields directly, ctrl_update
//                 pulses at every control EOP and ctrl_error is tied to 0.
// ---------------------------------------------------------------------------
module brightness_control_decode #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_BITS   = 8,
    parameter int DATA_PLANES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    brightness_control_decode_if.slave  bus,
    output logic [15:0]                 video_width,
    output logic [15:0]                 video_height,
    output logic [3:0]                  video_interlaced,
    output logic                        ctrl_update,
    output logic                        ctrl_error
);
    localparam int NIBBLES = 9;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_CTRL  = 4'b0010,
        ST_VIDEO = 4'b0100,
        ST_SKIP  = 4'b1000
    } state_e;

    state_e                state_q, state_d;
    logic                  first_pix_q, first_pix_d;
    logic [3:0]            nib_cnt_q, nib_cnt_d;
    // Packed {width, height, interlaced}; nibble n lives at bits [35-4n -: 4].
    logic [35:0]           fields_q, fields_d;
    logic                  ctrl_update_q, ctrl_update_d;
`ifdef BRIGHTNESS_CONTROL_DECODE_CHECK_EN
    logic [35:0]           shadow_q, shadow_d;
    logic                  ctrl_error_q, ctrl_error_d;
`endif

    logic [DATA_WIDTH-1:0] dout_data_q, dout_data_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  dout_sop_q, dout_sop_d;
    logic                  dout_eop_q, dout_eop_d;

    logic                  din_ready;
    logic                  din_xfer;
    logic [3:0]            hdr_type;

    assign din_ready = !rst && (!dout_valid_q || bus.dout_ready);
    assign din_xfer  = bus.din_valid && din_ready;
    assign hdr_type  = bus.din_data[3:0];

    // Drop this beat's DATA_PLANES nibbles into the field vector, starting at
    // nibble index cnt; anything past the 9th nibble is ignored.
    function automatic logic [35:0] put_nibbles(input logic [35:0]           fld,
                                                input logic [3:0]            cnt,
                                                input logic [DATA_WIDTH-1:0] data);
        logic [35:0] r;
        int          idx;
        r = fld;
        for (int k = 0; k < DATA_PLANES; k++) begin
            idx = int'(cnt) + k;
            if (idx < NIBBLES) begin
                r[35 - 4*idx -: 4] = data[k*DATA_BITS +: 4];
            end
        end
        return r;
    endfunction

    // Nibble counter saturates at 9 so long packets cannot wrap it.
    function automatic logic [3:0] cnt_advance(input logic [3:0] cnt);
        int n;
        n = int'(cnt) + DATA_PLANES;
        if (n > NIBBLES) begin
            n = NIBBLES;
        end
        return 4'(n);
    endfunction

    always_comb begin
        state_d       = state_q;
        first_pix_d   = first_pix_q;
        nib_cnt_d     = nib_cnt_q;
        fields_d      = fields_q;
        ctrl_update_d = 1'b0;
`ifdef BRIGHTNESS_CONTROL_DECODE_CHECK_EN
        shadow_d      = shadow_q;
        ctrl_error_d  = 1'b0;
`endif
        dout_data_d   = dout_data_q;
        dout_sop_d    = dout_sop_q;
        dout_eop_d    = dout_eop_q;
        dout_valid_d  = dout_valid_q && !bus.dout_ready;

        if (din_xfer) begin
            if (bus.din_startofpacket) begin
                // Any SOP is a fresh header, whatever state we were in; an
                // open output packet is simply abandoned.
                case (hdr_type)
                    4'h0: begin
                        state_d     = ST_VIDEO;
                        first_pix_d = 1'b1;
                    end
                    4'hF: begin
                        state_d   = ST_CTRL;
                        nib_cnt_d = '0;
                    end
                    default: state_d = ST_SKIP;
                endcase
                // A header-only packet carries nothing to parse or forward.
                if (bus.din_endofpacket) begin
                    state_d = ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_CTRL: begin
                        nib_cnt_d = cnt_advance(nib_cnt_q);
`ifdef BRIGHTNESS_CONTROL_DECODE_CHECK_EN
                        shadow_d = put_nibbles(shadow_q, nib_cnt_q, bus.din_data);
                        if (bus.din_endofpacket) begin
                            if (nib_cnt_d == 4'(NIBBLES)) begin
                                fields_d      = shadow_d;
                                ctrl_update_d = 1'b1;
                            end else begin
                                ctrl_error_d  = 1'b1;
                            end
                        end
`else
                        fields_d = put_nibbles(fields_q, nib_cnt_q, bus.din_data);
                        if (bus.din_endofpacket) begin
                            ctrl_update_d = 1'b1;
                        end
`endif
                        if (bus.din_endofpacket) begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_VIDEO: begin
                        dout_valid_d = 1'b1;
                        dout_data_d  = bus.din_data;
                        dout_sop_d   = first_pix_q;
                        dout_eop_d   = bus.din_endofpacket;
                        first_pix_d  = 1'b0;
                        if (bus.din_endofpacket) begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_SKIP: begin
                        if (bus.din_endofpacket) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        // IDLE: stray non-SOP beats are swallowed.
                    end
                endcase
            end
        end
    end

    // ---- register stage: control state and the single output beat ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            first_pix_q   <= 1'b0;
            nib_cnt_q     <= '0;
            fields_q      <= '0;
            ctrl_update_q <= 1'b0;
`ifdef BRIGHTNESS_CONTROL_DECODE_CHECK_EN
            shadow_q      <= '0;
            ctrl_error_q  <= 1'b0;
`endif
            dout_data_q   <= '0;
            dout_valid_q  <= 1'b0;
            dout_sop_q    <= 1'b0;
            dout_eop_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            first_pix_q   <= first_pix_d;
            nib_cnt_q     <= nib_cnt_d;
            fields_q      <= fields_d;
            ctrl_update_q <= ctrl_update_d;
`ifdef BRIGHTNESS_CONTROL_DECODE_CHECK_EN
            shadow_q      <= shadow_d;
            ctrl_error_q  <= ctrl_error_d;
`endif
            dout_data_q   <= dout_data_d;
            dout_valid_q  <= dout_valid_d;
            dout_sop_q    <= dout_sop_d;
            dout_eop_q    <= dout_eop_d;
        end
    end

    assign bus.din_ready          = din_ready;
    assign bus.dout_data          = dout_data_q;
    assign bus.dout_valid         = dout_valid_q;
    assign bus.dout_startofpacket = dout_sop_q;
    assign bus.dout_endofpacket   = dout_eop_q;

    assign video_width      = fields_q[35:20];
    assign video_height     = fields_q[19:4];
    assign video_interlaced = fields_q[3:0];
    assign ctrl_update      = ctrl_update_q;
`ifdef BRIGHTNESS_CONTROL_DECODE_CHECK_EN
    assign ctrl_error       = ctrl_error_q;
`else
    assign ctrl_error       = 1'b0;
`endif
endmodule

// File: tb/tb_brightness_control_decode.sv
// ---------------------------------------------------------------------------
// tb_brightness_control_decode
//   Three decoder instances (1, 2 and 3 planes of 8 bits) driven by directed
//   steps from one initial block. Forwarded pixels are pushed to a scoreboard
//   when accepted and popped when the 3-plane instance presents them.
// ---------------------------------------------------------------------------
module tb_brightness_control_decode;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    brightness_control_decode_if #(.DATA_WIDTH(8))  if1 ();
    brightness_control_decode_if #(.DATA_WIDTH(16)) if2 ();
    brightness_control_decode_if #(.DATA_WIDTH(24)) if3 ();

    logic [15:0] vw1, vh1, vw2, vh2, vw3, vh3;
    logic [3:0]  vi1, vi2, vi3;
    logic        upd1, upd2, upd3, err1, err2, err3;

    brightness_control_decode #(.DATA_WIDTH(8), .DATA_BITS(8), .DATA_PLANES(1)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave),
        .video_width(vw1), .video_height(vh1), .video_interlaced(vi1),
        .ctrl_update(upd1), .ctrl_error(err1));
    brightness_control_decode #(.DATA_WIDTH(16), .DATA_BITS(8), .DATA_PLANES(2)) u2 (
        .clk(clk), .rst(rst), .bus(if2.slave),
        .video_width(vw2), .video_height(vh2), .video_interlaced(vi2),
        .ctrl_update(upd2), .ctrl_error(err2));
    brightness_control_decode #(.DATA_WIDTH(24), .DATA_BITS(8), .DATA_PLANES(3)) u3 (
        .clk(clk), .rst(rst), .bus(if3.slave),
        .video_width(vw3), .video_height(vh3), .video_interlaced(vi3),
        .ctrl_update(upd3), .ctrl_error(err3));

    // dout_ready for instance 3: fixed level, or the repeating 1,0,0,1 pattern.
    logic       rdy3 = 1'b1;
    logic       tog_en = 1'b0;
    logic [3:0] tog_pat = 4'b1001;
    logic [1:0] tog_i = 2'd0;
    always @(posedge clk) tog_i <= tog_i + 2'd1;
    assign if3.dout_ready = tog_en ? tog_pat[tog_i] : rdy3;
    assign if1.dout_ready = 1'b1;
    assign if2.dout_ready = 1'b1;

    typedef struct {
        logic [23:0] data;
        logic        sop;
        logic        eop;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    logic lat_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---- output monitors ----
    int   outs1 = 0, outs2 = 0, outs3 = 0;
    int   nupd1 = 0, nupd2 = 0, nupd3 = 0, nerr1 = 0, nerr2 = 0, nerr3 = 0;
    int   nstall = 0;
    logic        stall_prev = 1'b0;
    logic [23:0] stall_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (if1.dout_valid) outs1++;
            if (if2.dout_valid) outs2++;
            if (upd1) nupd1++;
            if (upd2) nupd2++;
            if (upd3) nupd3++;
            if (err1) nerr1++;
            if (err2) nerr2++;
            if (err3) nerr3++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   n;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            check("din_ready3", if3.din_ready, !(if3.dout_valid && !if3.dout_ready));
            if (stall_prev) begin
                check("stall_valid", if3.dout_valid, 1'b1);
                check("stall_data", if3.dout_data, stall_data);
            end
            if (if3.dout_valid && if3.dout_ready) begin
                outs3++;
                n = sb.size();
                check("sb_nonempty", n != 0, 1'b1);
                if (n != 0) begin
                    e = sb.pop_front();
                    check("out_data", if3.dout_data, e.data);
                    check("out_sop", if3.dout_startofpacket, e.sop);
                    check("out_eop", if3.dout_endofpacket, e.eop);
                    if (lat_chk) check("latency", cyc - e.cyc, 1);
                end
            end
            stall_prev = if3.dout_valid && !if3.dout_ready;
            if (stall_prev) nstall++;
            stall_data = if3.dout_data;
        end
    end

    // ---- stimulus helpers ----
    task automatic drive(input int p, input logic [23:0] d, input logic s, input logic e, input logic v);
        case (p)
            1: begin
                if1.din_data = d[7:0]; if1.din_startofpacket = s;
                if1.din_endofpacket = e; if1.din_valid = v;
            end
            2: begin
                if2.din_data = d[15:0]; if2.din_startofpacket = s;
                if2.din_endofpacket = e; if2.din_valid = v;
            end
            default: begin
                if3.din_data = d; if3.din_startofpacket = s;
                if3.din_endofpacket = e; if3.din_valid = v;
            end
        endcase
    endtask

    task automatic send(input int p, input logic [23:0] d, input logic s, input logic e, output int acc_cyc);
        int   guard;
        logic acc;
        guard   = 0;
        acc     = 1'b0;
        acc_cyc = 0;
        drive(p, d, s, e, 1'b1);
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = (p == 1) ? if1.din_ready : (p == 2) ? if2.din_ready : if3.din_ready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            guard++;
        end
        drive(p, d, 1'b0, 1'b0, 1'b0);
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL handshake_timeout: observed no din_ready on port %0d expected acceptance", p);
        end
    endtask

    // Send a video pixel (non-SOP) on instance 3 and queue its expected output.
    task automatic px3(input logic [23:0] d, input logic exp_sop, input logic e);
        int a;
        send(3, d, 1'b0, e, a);
        sb.push_back('{data: d, sop: exp_sop, eop: e, cyc: a});
    endtask

    initial begin
        int          a;
        int          o0;
        logic [7:0]  c1 [10];
        logic [15:0] c2 [6];

        rst = 1'b1;
        drive(1, '0, 1'b0, 1'b0, 1'b0);
        drive(2, '0, 1'b0, 1'b0, 1'b0);
        drive(3, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_din_ready", if3.din_ready, 1'b0);
        check("rst_dout_valid", if3.dout_valid, 1'b0);
        check("rst_dout_data", if3.dout_data, 24'h0);
        check("rst_dout_sop", if3.dout_startofpacket, 1'b0);
        check("rst_dout_eop", if3.dout_endofpacket, 1'b0);
        check("rst_width", vw3, 16'h0);
        check("rst_height", vh3, 16'h0);
        check("rst_interlaced", vi3, 4'h0);
        check("rst_update", upd3, 1'b0);
        check("rst_error", err2, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Control packet, 1 plane: width 0x0280, height 0x01E0, interlaced 3.
        c1 = '{8'h0F, 8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h01, 8'h0E, 8'h00, 8'h03};
        for (int i = 0; i < 10; i++) send(1, {16'h0, c1[i]}, i == 0, i == 9, a);
        @(negedge clk);
        check("p1_update_pulse", upd1, 1'b1);
        check("p1_width", vw1, 16'h0280);
        check("p1_height", vh1, 16'h01E0);
        check("p1_interlaced", vi1, 4'h3);
        @(negedge clk);
        check("p1_update_drop", upd1, 1'b0);
        check("p1_update_count", nupd1, 1);
        check("p1_no_output", outs1, 0);

        // Control packet, 3 planes: width 0x1234, height 0x5678, interlaced 9.
        send(3, 24'h00000F, 1'b1, 1'b0, a);
        send(3, 24'h030201, 1'b0, 1'b0, a);
        send(3, 24'h060504, 1'b0, 1'b0, a);
        send(3, 24'h090807, 1'b0, 1'b1, a);
        @(negedge clk);
        check("p3_update_pulse", upd3, 1'b1);
        check("p3_width", vw3, 16'h1234);
        check("p3_height", vh3, 16'h5678);
        check("p3_interlaced", vi3, 4'h9);

        // Video packet at full rate: each pixel one cycle after acceptance.
        lat_chk = 1'b1;
        o0 = outs3;
        send(3, 24'h000000, 1'b1, 1'b0, a);
        px3(24'h112233, 1'b1, 1'b0);
        px3(24'h445566, 1'b0, 1'b0);
        px3(24'h778899, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        lat_chk = 1'b0;
        check("video_beats", outs3 - o0, 3);
        check("video_drained", sb.size(), 0);

        // Same packet under toggling dout_ready.
        tog_en = 1'b1;
        o0 = outs3;
        send(3, 24'h000000, 1'b1, 1'b0, a);
        px3(24'h112233, 1'b1, 1'b0);
        px3(24'h445566, 1'b0, 1'b0);
        px3(24'h778899, 1'b0, 1'b1);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        #1 tog_en = 1'b0;
        check("toggle_beats", outs3 - o0, 3);
        check("toggle_drained", sb.size(), 0);
        check("toggle_stalled", nstall > 0, 1'b1);

        // Type 0x3 packet, then a header-only video packet: nothing out.
        o0 = outs3;
        send(3, 24'h000003, 1'b1, 1'b0, a);
        send(3, 24'hAAAAAA, 1'b0, 1'b0, a);
        send(3, 24'hBBBBBB, 1'b0, 1'b0, a);
        send(3, 24'hCCCCCC, 1'b0, 1'b1, a);
        send(3, 24'h000000, 1'b1, 1'b1, a);
        repeat (3) @(negedge clk);
        check("skip_no_output", outs3 - o0, 0);
        check("skip_width", vw3, 16'h1234);
        check("skip_height", vh3, 16'h5678);
        check("skip_interlaced", vi3, 4'h9);
        check("skip_update_count", nupd3, 1);

        // 2 planes: full control packet, then a short one (nibbles 0,2,8,0).
        c2 = '{16'h000F, 16'h0B0A, 16'h0D0C, 16'h0301, 16'h0705, 16'h0F02};
        for (int i = 0; i < 6; i++) send(2, {8'h0, c2[i]}, i == 0, i == 5, a);
        @(negedge clk);
        check("p2_update_pulse", upd2, 1'b1);
        check("p2_width", vw2, 16'hABCD);
        check("p2_height", vh2, 16'h1357);
        check("p2_interlaced", vi2, 4'h2);
        send(2, 24'h00000F, 1'b1, 1'b0, a);
        send(2, 24'h000200, 1'b0, 1'b0, a);
        send(2, 24'h000008, 1'b0, 1'b1, a);
        @(negedge clk);
`ifdef BRIGHTNESS_CONTROL_DECODE_CHECK_EN
        check("short_error_pulse", err2, 1'b1);
        check("short_no_update", upd2, 1'b0);
        check("short_width", vw2, 16'hABCD);
        check("short_height", vh2, 16'h1357);
        check("short_interlaced", vi2, 4'h2);
        @(negedge clk);
        check("short_error_drop", err2, 1'b0);
        check("short_update_count", nupd2, 1);
        check("short_error_count", nerr2, 1);
`else
        check("short_update_pulse", upd2, 1'b1);
        check("short_error", err2, 1'b0);
        check("short_width", vw2, 16'h0280);
        check("short_height", vh2, 16'h1357);
        check("short_interlaced", vi2, 4'h2);
        @(negedge clk);
        check("short_update_count", nupd2, 2);
        check("short_error_count", nerr2, 0);
`endif
        check("p2_no_output", outs2, 0);

        // Reset while the output register holds a stalled video beat.
        rdy3 = 1'b0;
        @(posedge clk);
        #1;
        send(3, 24'h000000, 1'b1, 1'b0, a);
        send(3, 24'hDEAD01, 1'b0, 1'b0, a);
        @(negedge clk);
        check("held_valid", if3.dout_valid, 1'b1);
        check("held_data", if3.dout_data, 24'hDEAD01);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", if3.din_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", if3.dout_valid, 1'b0);
        check("rst_mid_width", vw3, 16'h0);
        rdy3 = 1'b1;
        o0 = outs3;
        send(3, 24'h111111, 1'b0, 1'b0, a);
        send(3, 24'h222222, 1'b0, 1'b1, a);
        repeat (2) @(negedge clk);
        check("post_rst_dropped", outs3 - o0, 0);
        send(3, 24'h000000, 1'b1, 1'b0, a);
        px3(24'h333333, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("post_rst_video", outs3 - o0, 1);

        check("final_drained", sb.size(), 0);
        check("no_error_p1", nerr1, 0);
        check("no_error_p3", nerr3, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
